// File: rtl/operand_fetch.sv
// Operand fetch stage: reads two source registers, forwards the writeback
// port into the operands, and holds a single registered instruction under a
// valid/ready handshake. While the held instruction is stalled, writebacks to
// its source registers refresh the held operands so they never go stale.
module operand_fetch #(
    parameter int unsigned W = 32,
    parameter int unsigned D = 5
) (
    input  logic         clk,
    input  logic         reset,

    // Upstream instruction
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [D-1:0] rs_a,
    input  logic [D-1:0] rs_b,
    input  logic [D-1:0] rd,
    input  logic         rd_we,

    // Register file read port (combinational data return)
    output logic [D-1:0] raddrA,
    output logic [D-1:0] raddrB,
    input  logic [W-1:0] rdataA,
    input  logic [W-1:0] rdataB,

    // Writeback port, shared with the register file write port
    input  logic         wb_en,
    input  logic [D-1:0] wb_addr,
    input  logic [W-1:0] wb_data,

    input  logic         flush,

    // Downstream instruction
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] opA,
    output logic [W-1:0] opB,
    output logic [D-1:0] out_rd,
    output logic         out_we,

    output logic [15:0]  stall_cnt
);

    // Registered state
    logic         valid_q,  valid_d;
    logic [W-1:0] op_a_q,   op_a_d;
    logic [W-1:0] op_b_q,   op_b_d;
    logic [D-1:0] rd_q,     rd_d;
    logic         we_q,     we_d;
    logic [D-1:0] held_a_q, held_a_d;
    logic [D-1:0] held_b_q, held_b_d;
    logic [15:0]  stall_q,  stall_d;

    // Handshake and bypass intermediates
    logic         accept;
    logic         hold;
    logic         stall_inc;
    logic [W-1:0] byp_a;
    logic [W-1:0] byp_b;
    logic         refresh_a;
    logic         refresh_b;

    // Register 0 is hard-wired to zero, so it wins over both the writeback
    // forward and whatever the register file returns for address 0.
    function automatic logic [W-1:0] bypass(
        input logic [D-1:0] rs,
        input logic [W-1:0] rdata,
        input logic         fwd_en,
        input logic [D-1:0] fwd_addr,
        input logic [W-1:0] fwd_data
    );
        logic [W-1:0] val;
        if (rs == '0) begin
            val = '0;
        end else if (fwd_en && (fwd_addr == rs)) begin
            val = fwd_data;
        end else begin
            val = rdata;
        end
        return val;
    endfunction

    // Read addresses come straight from the incoming instruction, independent of in_valid
    always_comb begin
        raddrA = rs_a;
        raddrB = rs_b;
    end

    // Handshake decode and operand bypass muxes
    always_comb begin
        in_ready  = !valid_q || out_ready;
        accept    = in_valid && in_ready && !flush;
        hold      = valid_q && !out_ready;
        stall_inc = valid_q && !out_ready && !flush;

        byp_a = bypass(rs_a, rdataA, wb_en, wb_addr, wb_data);
        byp_b = bypass(rs_b, rdataB, wb_en, wb_addr, wb_data);

        // A write to register 0 is never forwarded into a held operand.
        refresh_a = wb_en && (wb_addr != '0) && (wb_addr == held_a_q);
        refresh_b = wb_en && (wb_addr != '0) && (wb_addr == held_b_q);
    end

    // Next-state for the held instruction: flush, then accept, then drain, then hold
    always_comb begin
        valid_d  = valid_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        rd_d     = rd_q;
        we_d     = we_q;
        held_a_d = held_a_q;
        held_b_d = held_b_q;

        if (flush) begin
            // Kills both the held instruction and anything offered this cycle.
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d  = 1'b1;
            op_a_d   = byp_a;
            op_b_d   = byp_b;
            rd_d     = rd;
            we_d     = rd_we && (rd != '0);
            held_a_d = rs_a;
            held_b_d = rs_b;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end else if (hold) begin
            if (refresh_a) begin
                op_a_d = wb_data;
            end
            if (refresh_b) begin
                op_b_d = wb_data;
            end
        end
    end

    // Stall counter next-state, saturating at all-ones
    always_comb begin
        stall_d = stall_q;
        if (stall_inc && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // State registers with asynchronous active-high reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= 1'b0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            rd_q     <= '0;
            we_q     <= 1'b0;
            held_a_q <= '0;
            held_b_q <= '0;
            stall_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            rd_q     <= rd_d;
            we_q     <= we_d;
            held_a_q <= held_a_d;
            held_b_q <= held_b_d;
            stall_q  <= stall_d;
        end
    end

    // Output mapping
    always_comb begin
        out_valid = valid_q;
        opA       = op_a_q;
        opB       = op_b_q;
        out_rd    = rd_q;
        out_we    = we_q;
        stall_cnt = stall_q;
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: a register file plus an
// architectural model of the stage, directed scenarios and a random phase.
module tb_operand_fetch;

    localparam int unsigned W = 32;
    localparam int unsigned D = 5;
    localparam int unsigned NREG = 2 ** D;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [D-1:0] rs_a, rs_b, rd;
    logic         rd_we;
    logic [D-1:0] raddrA, raddrB;
    logic [W-1:0] rdataA, rdataB;
    logic         wb_en;
    logic [D-1:0] wb_addr;
    logic [W-1:0] wb_data;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] opA, opB;
    logic [D-1:0] out_rd;
    logic         out_we;
    logic [15:0]  stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    operand_fetch #(.W(W), .D(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs_a      (rs_a),
        .rs_b      (rs_b),
        .rd        (rd),
        .rd_we     (rd_we),
        .raddrA    (raddrA),
        .raddrB    (raddrB),
        .rdataA    (rdataA),
        .rdataB    (rdataB),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .opA       (opA),
        .opB       (opB),
        .out_rd    (out_rd),
        .out_we    (out_we),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    // Bench register file. It stores writes to register 0 on purpose, so a
    // read of address 0 returns garbage that the stage must ignore.
    logic [W-1:0] mem [NREG];
    assign rdataA = mem[raddrA];
    assign rdataB = mem[raddrB];

    // Architectural model of the single output slot
    logic         m_valid;
    logic [W-1:0] m_opa, m_opb;
    logic [D-1:0] m_rd;
    logic         m_we;
    logic [D-1:0] m_ha, m_hb;
    logic [15:0]  m_stall;

    // Value register r has once this cycle's writeback is taken into account
    function automatic logic [W-1:0] arch_val(input logic [D-1:0] r);
        if (r == 0) return '0;
        if (wb_en && wb_addr == r) return wb_data;
        return mem[r];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_opa   <= '0;
            m_opb   <= '0;
            m_rd    <= '0;
            m_we    <= 1'b0;
            m_ha    <= '0;
            m_hb    <= '0;
            m_stall <= '0;
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else begin
            if (m_valid && !out_ready && !flush && m_stall != 16'hFFFF)
                m_stall <= m_stall + 16'd1;
            if (flush) begin
                m_valid <= 1'b0;
            end else if (in_valid && (!m_valid || out_ready)) begin
                m_valid <= 1'b1;
                m_opa   <= arch_val(rs_a);
                m_opb   <= arch_val(rs_b);
                m_rd    <= rd;
                m_we    <= rd_we && rd != 0;
                m_ha    <= rs_a;
                m_hb    <= rs_b;
            end else if (m_valid && !out_ready) begin
                if (wb_en && wb_addr != 0 && wb_addr == m_ha) m_opa <= wb_data;
                if (wb_en && wb_addr != 0 && wb_addr == m_hb) m_opb <= wb_data;
            end else begin
                m_valid <= 1'b0;
            end
            if (wb_en) mem[wb_addr] <= wb_data;
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge
    always @(negedge clk) begin
        if (!reset) begin
            chk("raddrA", W'(raddrA), W'(rs_a));
            chk("raddrB", W'(raddrB), W'(rs_b));
            chk("in_ready", W'(in_ready), W'(!m_valid || out_ready));
            chk("out_valid", W'(out_valid), W'(m_valid));
            chk("stall_cnt", W'(stall_cnt), W'(m_stall));
            if (m_valid) begin
                chk("opA", opA, m_opa);
                chk("opB", opB, m_opb);
                chk("out_rd", W'(out_rd), W'(m_rd));
                chk("out_we", W'(out_we), W'(m_we));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [D-1:0] a, input logic [D-1:0] b,
                         input logic [D-1:0] d, input logic dwe, input logic orr,
                         input logic fl, input logic we, input logic [D-1:0] wa,
                         input logic [W-1:0] wd);
        in_valid = iv; rs_a = a; rs_b = b; rd = d; rd_we = dwe; out_ready = orr;
        flush = fl; wb_en = we; wb_addr = wa; wb_data = wd;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
        #3;
        chk("rst out_valid", W'(out_valid), 0);
        chk("rst in_ready", W'(in_ready), 1);
        chk("rst opA", opA, 0);
        chk("rst stall", W'(stall_cnt), 0);
        #9;
        reset = 1'b0;

        // Load register 1, then plain read
        drive(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd1, 32'h6789ABCD);
        step();
        drive(1'b1, 5'd1, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
        step();
        chk("plain out_valid", W'(out_valid), 1);
        chk("plain opA", opA, 32'h6789ABCD);
        chk("plain opB", opB, 0);
        chk("plain out_we", W'(out_we), 1);

        // Same-cycle bypass over stale register file data; rd=0 suppresses out_we
        drive(1'b1, 5'd2, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd2, 32'h0000ABCD);
        step();
        chk("bypass opA", opA, 32'h0000ABCD);
        chk("rd0 out_we", W'(out_we), 0);

        // Write to register 0 is not forwarded
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 32'hFEDC2030);
        step();
        chk("zero opB", opB, 0);
        chk("zero opA", opA, 0);

        // Stall with held-operand refresh
        drive(1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
        step();
        drive(1'b1, 5'd9, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        step();
        chk("stall in_ready c1", W'(in_ready), 0);
        drive(1'b1, 5'd9, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'h12345678);
        step();
        chk("stall in_ready c2", W'(in_ready), 0);
        drive(1'b1, 5'd9, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        step();
        chk("stall in_ready c3", W'(in_ready), 0);
        chk("refresh opA", opA, 32'h12345678);
        chk("refresh opB", opB, 0);
        chk("stall count", W'(stall_cnt), 3);
        chk("stall out_rd", W'(out_rd), 7);
        drive(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
        step();
        chk("drain out_valid", W'(out_valid), 0);

        // Flush beats accept; next accept proceeds
        drive(1'b1, 5'd5, 5'd0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, '0, '0);
        step();
        chk("flush out_valid", W'(out_valid), 0);
        drive(1'b1, 5'd5, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
        step();
        chk("post-flush out_valid", W'(out_valid), 1);
        chk("post-flush opA", opA, 32'h12345678);

        // Asynchronous reset during a hold
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        step();
        chk("hold out_valid", W'(out_valid), 1);
        #1 reset = 1'b1;
        #1;
        chk("areset out_valid", W'(out_valid), 0);
        chk("areset in_ready", W'(in_ready), 1);
        chk("areset opA", opA, 0);
        chk("areset opB", opB, 0);
        chk("areset out_rd", W'(out_rd), 0);
        chk("areset stall", W'(stall_cnt), 0);
        #4 reset = 1'b0;
        drive(1'b1, 5'd4, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 32'hCAFE0001);
        step();
        chk("after-reset out_valid", W'(out_valid), 1);
        chk("after-reset opA", opA, 32'hCAFE0001);
        chk("after-reset stall", W'(stall_cnt), 0);

        // Random phase with small address space for frequent hazards
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 9) < 7), D'($urandom_range(0, 7)), D'($urandom_range(0, 7)),
                  D'($urandom_range(0, 7)), 1'($urandom), ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 9) == 0), 1'($urandom), D'($urandom_range(0, 7)),
                  $urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter W, default 32: data word width, matches the register file word width.
REQ-002 Parameter D, default 5: register address width; 2**D registers, with register 0 reading as zero.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 reset  input  1: asynchronous, active-high reset.
REQ-005 in_valid  input  1: an upstream instruction is present.
REQ-006 in_ready  output  1: the stage accepts an instruction this cycle.
REQ-007 rs_a, rs_b  input  D each: source register addresses of the incoming instruction.
REQ-008 rd  input  D: destination register of the incoming instruction.
REQ-009 rd_we  input  1: the incoming instruction writes rd.
REQ-010 raddrA, raddrB  output  D each: read addresses driven to the register file.
REQ-011 rdataA, rdataB  input  W each: combinational read data returned by the register file.
REQ-012 wb_en, wb_addr, wb_data  input  1/D/W: writeback port, the same signals that drive the register file write port.
REQ-013 flush  input  1: synchronous kill of the held instruction and of any instruction accepted this cycle.
REQ-014 out_valid  output  1: opA/opB/out_rd/out_we hold a valid instruction.
REQ-015 out_ready  input  1: downstream consumes the instruction this cycle.
REQ-016 opA, opB  output  W each: registered operands.
REQ-017 out_rd, out_we  output  D/1: registered destination register and its write enable.
REQ-018 stall_cnt  output  16: saturating count of stall cycles.

Function
REQ-019 raddrA and raddrB shall equal rs_a and rs_b combinationally, with no dependence on in_valid.
REQ-020 Bypass: the operand for each source = 0 if rs==0; else wb_data if wb_en && wb_addr==rs; else rdata.
REQ-021 in_ready shall equal (!out_valid || out_ready).
REQ-022 Accept: on a rising edge with in_valid && in_ready && !flush, load the following, and set out_valid=1:
- bypassed operands into opA/opB;
- rd into out_rd;
- rd_we && (rd!=0) into out_we;
- rs_a/rs_b into internal held_a/held_b.
REQ-023 Drain: on an edge with out_valid && out_ready and no accept, clear out_valid to 0.
REQ-024 Hold: while out_valid && !out_ready, all outputs shall keep their values, with one exception: the held-operand refresh.
REQ-025 Held-operand refresh: during a hold cycle, if wb_en && wb_addr!=0 && wb_addr==held_a, then opA <= wb_data on that edge; the same rule applies independently to opB with held_b.
REQ-026 Flush has priority over both accept and hold: on an edge with flush=1, out_valid <= 0 and the incoming instruction is discarded; in_ready is unaffected that cycle.
REQ-027 Latency: one cycle from acceptance to out_valid; back-to-back acceptance at one per cycle when out_ready is held at 1.
REQ-028 When out_valid=0, opA/opB/out_rd/out_we shall retain their last values and are don't-care to downstream.
REQ-029 stall_cnt shall increment by 1 on each edge with out_valid && !out_ready && !flush, and shall saturate at 16'hFFFF.
REQ-030 Writes to register 0 on the writeback port shall never be bypassed into either operand.

Reset
REQ-031 When reset is asserted, immediately and regardless of clk:
- out_valid, out_we, out_rd, opA, opB, held_a, held_b and stall_cnt = 0;
- in_ready = 1.
REQ-032 Reset asserted mid-hold shall discard the held instruction; the first edge after deassertion behaves as accept-from-empty.

Verification
REQ-033 Plain read: reg 1 = 32'h6789ABCD, rs_a=1, rs_b=0, accept -> next cycle opA=32'h6789ABCD, opB=0, out_valid=1.
REQ-034 Same-cycle bypass: wb_en=1, wb_addr=2, wb_data=32'h0000ABCD, rs_a=2, rdataA stale=0 -> opA=32'h0000ABCD.
REQ-035 Zero-register guard: wb_en=1, wb_addr=0, wb_data=32'hFEDC2030, rs_b=0 -> opB=0; also rd=0 with rd_we=1 -> out_we=0.
REQ-036 Stall with refresh: out_ready=0 for 3 cycles, held_a=5, wb write of 32'h12345678 to reg 5 in cycle 2 -> the following hold:
- opA=32'h12345678;
- in_ready=0 throughout;
- stall_cnt=3;
- after out_ready=1, out_valid drops next edge.
REQ-037 Flush versus accept: in_valid=1, out_ready=1, flush=1 on the same edge -> out_valid=0 next cycle; the next unflushed accept proceeds normally.
REQ-038 Async reset: assert reset for 5 ns between edges during a hold -> all outputs 0 and in_ready=1 before the next edge.
